wb_dm_cache: RTL and testbench
==============================

WB_DM_CACHE -- requirements
Module: wb_dm_cache

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, word width; ADDR_W, default 8, word-address width; INDEX_W, default 4, line-index bits (2**INDEX_W lines, one word per line); CNT_W, default 16, statistics counter width.
REQ-002 Derived TAG_W SHALL equal ADDR_W-INDEX_W; index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W].
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  request strobe, sampled only when cpu_busy=0.
REQ-006 cpu_rw  in  1  0=read, 1=write.
REQ-007 cpu_addr  in  ADDR_W  request address.
REQ-008 cpu_wdata  in  DATA_W  write data.
REQ-009 cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1.
REQ-010 cpu_ack  out  1  one-cycle completion pulse per accepted request.
REQ-011 cpu_busy  out  1  high whenever FSM is not IDLE.
REQ-012 ram_req  out  1  RAM transaction request (level, held until ram_ack).
REQ-013 ram_rw  out  1  0=fill read, 1=write-back.
REQ-014 ram_addr  out  ADDR_W  RAM word address.
REQ-015 ram_wdata  out  DATA_W  write-back data.
REQ-016 ram_rdata  in  DATA_W  fill data, valid with ram_ack.
REQ-017 ram_ack  in  1  RAM completion, ignored unless ram_req=1.
REQ-018 hit_count, miss_count  out  CNT_W  saturating statistics counters.

Function
REQ-019 Each line SHALL hold valid, dirty, tag, data; hit = valid && stored tag == request tag.
REQ-020 FSM states SHALL be IDLE, WB, GAP, FILL; requests latched (addr, rw, wdata) at acceptance edge.
REQ-021 IDLE read hit: cpu_rdata=line data, cpu_ack=1 on the following cycle; no RAM activity; hit_count+1.
REQ-022 IDLE write hit: line data<=cpu_wdata, dirty<=1, cpu_ack next cycle; hit_count+1.
REQ-023 Any miss SHALL increment miss_count once, at acceptance.
REQ-024 Write miss, victim invalid or clean: install line {valid=1, dirty=1, tag, cpu_wdata}, cpu_ack next cycle, no RAM access (write-allocate, no fetch).
REQ-025 Read miss, victim invalid or clean: next cycle enter FILL with ram_req=1, ram_rw=0, ram_addr=cpu_addr.
REQ-026 Miss with valid dirty victim: next cycle enter WB with ram_req=1, ram_rw=1, ram_addr={victim tag, index}, ram_wdata=victim data.
REQ-027 WB on ram_ack: ram_req<=0, victim dirty<=0; pending write -> install as REQ-024, cpu_ack next cycle, IDLE; pending read -> GAP.
REQ-028 GAP SHALL last exactly one cycle with ram_req=0, then FILL with ram_req=1, ram_rw=0, ram_addr=latched addr.
REQ-029 FILL on ram_ack: line <= {valid=1, dirty=0, tag, ram_rdata}; cpu_rdata<=ram_rdata; cpu_ack pulse next cycle; ram_req<=0; IDLE.
REQ-030 ram_addr/ram_wdata/ram_rw SHALL be stable while ram_req=1; ram_req SHALL be low at least one cycle between transactions.
REQ-031 cpu_req while cpu_busy=1 SHALL be ignored (not queued, not counted).
REQ-032 cpu_ack SHALL never exceed one cycle; next request acceptable the cycle cpu_ack is high.
REQ-033 Counters SHALL saturate at 2**CNT_W-1, never wrap.

Reset
REQ-034 clr=1 at a posedge SHALL: FSM->IDLE; all valid and dirty bits cleared (dirty data discarded); cpu_ack, cpu_busy, ram_req, ram_rw=0; cpu_rdata, ram_addr, ram_wdata=0; counters=0.
REQ-035 clr SHALL take priority over cpu_req and ram_ack in the same cycle, including mid-WB/FILL; no cpu_ack issued for the aborted request.

Verification (DATA_W=8, ADDR_W=8, INDEX_W=4)
REQ-036 Reset; read 0x35 -> ram_req rw=0 addr 0x35; ram_ack rdata 0xA5 after 3 cycles -> cpu_ack, rdata 0xA5; reread 0x35 -> ack next cycle, no ram_req; hit_count=1, miss_count=1.
REQ-037 Write 0x12/0x5C -> ack next cycle, no RAM; write 0x22/0x77 -> ram_req rw=1 addr 0x12 wdata 0x5C; after ack, read 0x22 hits returning 0x77.
REQ-038 Dirty line 0x12/0x5C; read 0x22 -> WB addr 0x12, one GAP cycle ram_req=0, FILL addr 0x22; ram_rdata 0x3C -> rdata 0x3C, line clean.
REQ-039 clr during WB with ram_req=1 -> next edge ram_req=0, cpu_busy=0, no cpu_ack; read 0x12 afterwards misses.
REQ-040 cpu_req pulsed during FILL ignored; ram_ack pulsed while ram_req=0 ignored; miss_count unchanged by ignored request.
REQ-041 CNT_W=4: 20 consecutive read hits -> hit_count=15, holds at 15.

Source files
------------

// File: rtl/wb_dm_cache.sv
// Direct-mapped, write-back, write-allocate cache between a CPU port and a RAM port.
// One word per line.
// Ports:
//   clk, clr              - clock, synchronous active-high reset
//   cpu_req/rw/addr/wdata - request strobe (taken only when not busy), direction, address, write data
//   cpu_rdata, cpu_ack    - read data and one-cycle completion pulse
//   cpu_busy              - high while a miss is being serviced
//   ram_req/rw/addr/wdata - level RAM request held until ram_ack (rw: 0 = fill, 1 = write-back)
//   ram_rdata, ram_ack    - fill data and RAM completion
//   hit_count, miss_count - saturating statistics counters
module wb_dm_cache #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  output logic              ram_req,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;
  localparam int unsigned LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, GAP, FILL} state_t;
  state_t state, state_d;

  logic              valid    [LINES];
  logic              dirty    [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [DATA_W-1:0] req_wdata;

  logic [INDEX_W-1:0] idx, lidx;
  logic [TAG_W-1:0]   tg, ltag;
  logic               hit;

  assign idx  = cpu_addr[INDEX_W-1:0];
  assign tg   = cpu_addr[ADDR_W-1:INDEX_W];
  assign lidx = req_addr[INDEX_W-1:0];
  assign ltag = req_addr[ADDR_W-1:INDEX_W];
  assign hit  = valid[idx] && (tag_mem[idx] == tg);

  // next-state / control
  logic              ack_d, ram_req_d, ram_rw_d, hit_inc, miss_inc, latch, clean_en;
  logic [DATA_W-1:0] rdata_d, ram_wdata_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              wr_en, wr_dirty;
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;

  // next-state and line-update decisions
  always_comb begin
    state_d     = state;
    ack_d       = 1'b0;
    rdata_d     = cpu_rdata;
    ram_req_d   = ram_req;
    ram_rw_d    = ram_rw;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    latch       = 1'b0;
    clean_en    = 1'b0;
    wr_en       = 1'b0;
    wr_dirty    = 1'b0;
    wr_idx      = '0;
    wr_tag      = '0;
    wr_data     = '0;
    unique case (state)
      IDLE: if (cpu_req) begin
        latch = 1'b1;
        if (hit) begin
          hit_inc = 1'b1;
          ack_d   = 1'b1;
          if (cpu_rw) begin
            wr_en = 1'b1; wr_dirty = 1'b1; wr_idx = idx; wr_tag = tg; wr_data = cpu_wdata;
          end else begin
            rdata_d = data_mem[idx];
          end
        end else begin
          miss_inc = 1'b1;
          if (valid[idx] && dirty[idx]) begin
            state_d     = WB;
            ram_req_d   = 1'b1;
            ram_rw_d    = 1'b1;
            ram_addr_d  = {tag_mem[idx], idx};
            ram_wdata_d = data_mem[idx];
          end else if (cpu_rw) begin
            // write-allocate without fetching: the whole word is overwritten
            wr_en = 1'b1; wr_dirty = 1'b1; wr_idx = idx; wr_tag = tg; wr_data = cpu_wdata;
            ack_d = 1'b1;
          end else begin
            state_d    = FILL;
            ram_req_d  = 1'b1;
            ram_rw_d   = 1'b0;
            ram_addr_d = cpu_addr;
          end
        end
      end
      WB: if (ram_ack) begin
        ram_req_d = 1'b0;
        clean_en  = 1'b1;
        if (req_rw) begin
          wr_en = 1'b1; wr_dirty = 1'b1; wr_idx = lidx; wr_tag = ltag; wr_data = req_wdata;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      // one idle cycle on the RAM port between write-back and fill
      GAP: begin
        state_d    = FILL;
        ram_req_d  = 1'b1;
        ram_rw_d   = 1'b0;
        ram_addr_d = req_addr;
      end
      FILL: if (ram_ack) begin
        wr_en = 1'b1; wr_dirty = 1'b0; wr_idx = lidx; wr_tag = ltag; wr_data = ram_rdata;
        rdata_d   = ram_rdata;
        ack_d     = 1'b1;
        ram_req_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_d;
  end

  // registered outputs, request latch and counters
  always_ff @(posedge clk) begin
    if (clr) begin
      cpu_ack    <= 1'b0;
      cpu_busy   <= 1'b0;
      cpu_rdata  <= '0;
      ram_req    <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      req_addr   <= '0;
      req_rw     <= 1'b0;
      req_wdata  <= '0;
    end else begin
      cpu_ack   <= ack_d;
      cpu_busy  <= (state_d != IDLE);
      cpu_rdata <= rdata_d;
      ram_req   <= ram_req_d;
      ram_rw    <= ram_rw_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if (latch) begin
        req_addr  <= cpu_addr;
        req_rw    <= cpu_rw;
        req_wdata <= cpu_wdata;
      end
    end
  end

  // line state; reset discards all contents including dirty data
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        valid[i] <= 1'b0;
        dirty[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end else if (clean_en) begin
      dirty[lidx] <= 1'b0;
    end
  end

  // line payload
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end
endmodule

// File: tb/tb_wb_dm_cache.sv
// Bench for wb_dm_cache: directed scenarios plus random traffic, checked against a
// flat architectural memory and a tag/valid/dirty occupancy model.
module tb_wb_dm_cache;
  logic       clk = 1'b0;
  logic       clr, cpu_req, cpu_rw, ram_ack;
  logic [7:0] cpu_addr, cpu_wdata, ram_rdata;
  logic [7:0] cpu_rdata, ram_addr, ram_wdata;
  logic       cpu_ack, cpu_busy, ram_req, ram_rw;
  logic [15:0] hit_count, miss_count;
  logic [7:0] cpu_rdata4, ram_addr4, ram_wdata4;
  logic       cpu_ack4, cpu_busy4, ram_req4, ram_rw4;
  logic [3:0] hit_count4, miss_count4;

  always #5 clk = ~clk;

  wb_dm_cache #(.DATA_W(8), .ADDR_W(8), .INDEX_W(4), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .ram_req(ram_req), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .hit_count(hit_count), .miss_count(miss_count));

  // narrow-counter copy fed the identical stimulus
  wb_dm_cache #(.DATA_W(8), .ADDR_W(8), .INDEX_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .clr(clr), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata4), .cpu_ack(cpu_ack4), .cpu_busy(cpu_busy4),
    .ram_req(ram_req4), .ram_rw(ram_rw4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .hit_count(hit_count4), .miss_count(miss_count4));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] arch    [256];
  logic       mv [16];
  logic       md [16];
  logic [3:0] mt [16];
  int h = 0;
  int m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 4'h0; end
    for (int i = 0; i < 256; i++) arch[i] = ram_mem[i];
    h = 0;
    m = 0;
  endtask

  task automatic chk_counts();
    chk("hit_count", 32'(hit_count), 32'(h));
    chk("miss_count", 32'(miss_count), 32'(m));
    chk("hit_count4", 32'(hit_count4), 32'((h > 15) ? 15 : h));
    chk("miss_count4", 32'(miss_count4), 32'((m > 15) ? 15 : m));
  endtask

  // one CPU access with a RAM responder; poke pulses a stray cpu_req while busy
  task automatic access(input logic rw, input logic [7:0] addr, input logic [7:0] wd, input bit poke);
    int         idx;
    logic [3:0] tg;
    bit         hit, exp_wb, exp_fill, done, poked, was_wb;
    logic [7:0] vaddr;
    logic [17:0] held;
    int         nwb, nfill, lat, ack_cyc;
    idx      = int'(addr[3:0]);
    tg       = addr[7:4];
    hit      = mv[idx] && (mt[idx] == tg);
    exp_wb   = !hit && mv[idx] && md[idx];
    exp_fill = !hit && !rw;
    vaddr    = {mt[idx], addr[3:0]};
    nwb = 0; nfill = 0; done = 0; poked = 0; ack_cyc = -1;
    if (hit) h++; else m++;
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
    step();
    cpu_req = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (cpu_ack) begin
        done = 1; ack_cyc = c;
      end else if (ram_req) begin
        was_wb = ram_rw;
        if (ram_rw) begin
          nwb++;
          chk("wb_addr", 32'(ram_addr), 32'(vaddr));
          chk("wb_data", 32'(ram_wdata), 32'(arch[vaddr]));
        end else begin
          nfill++;
          chk("fill_addr", 32'(ram_addr), 32'(addr));
        end
        held = {ram_req, ram_rw, ram_addr, ram_wdata};
        lat  = poke ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        for (int k = 0; k < lat; k++) begin
          if (poke && !poked) begin
            cpu_req = 1'b1; cpu_rw = 1'($urandom); cpu_addr = 8'($urandom); poked = 1;
          end
          step();
          cpu_req = 1'b0;
          chk("ram_hold", 32'(held), 32'({ram_req, ram_rw, ram_addr, ram_wdata}));
        end
        ram_ack = 1'b1;
        if (ram_rw) ram_mem[ram_addr] = ram_wdata;
        else        ram_rdata = ram_mem[ram_addr];
        step();
        ram_ack = 1'b0;
        ram_rdata = 8'($urandom);
        chk("ram_drop", 32'(ram_req), 32'd0);
        if (was_wb && !rw) begin
          step();
          chk("gap_one_cycle", 32'(ram_req), 32'd1);
        end
      end else begin
        step();
      end
    end
    chk("ack_seen", 32'(done), 32'd1);
    chk("n_wb", 32'(nwb), 32'(exp_wb));
    chk("n_fill", 32'(nfill), 32'(exp_fill));
    if (!exp_wb && !exp_fill) chk("ack_latency", 32'(ack_cyc), 32'd0);
    if (!rw) chk("rdata", 32'(cpu_rdata), 32'(arch[addr]));
    chk_counts();
    if (rw) arch[addr] = wd;
    md[idx] = rw ? 1'b1 : (hit ? md[idx] : 1'b0);
    mv[idx] = 1'b1;
    mt[idx] = tg;
  endtask

  initial begin
    clr = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ram_ack = 1'b0; ram_rdata = '0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'($urandom);
    ram_mem[8'h35] = 8'hA5;
    model_reset();
    step(); step();
    chk("rst_outputs", 32'({cpu_ack, cpu_busy, ram_req, ram_rw, cpu_rdata, ram_addr, ram_wdata}), 32'd0);
    chk_counts();
    clr = 1'b0;
    step();

    // read miss, then reread hits
    access(1'b0, 8'h35, 8'h00, 0);
    access(1'b0, 8'h35, 8'h00, 0);
    step();
    chk("ack_one_cycle", 32'(cpu_ack), 32'd0);

    // write allocate, then dirty eviction by a write
    access(1'b1, 8'h12, 8'h5C, 0);
    access(1'b1, 8'h22, 8'h77, 0);
    access(1'b0, 8'h22, 8'h00, 0);

    // dirty eviction by a read: write-back, gap, fill; line then clean
    access(1'b1, 8'h12, 8'h5C, 0);
    ram_mem[8'h22] = 8'h3C;
    arch[8'h22]    = 8'h3C;
    access(1'b0, 8'h22, 8'h00, 0);
    access(1'b0, 8'h32, 8'h00, 0);

    // reset in the middle of a write-back, with ram_ack in the same cycle
    access(1'b1, 8'h12, 8'h5C, 0);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h22;
    step();
    cpu_req = 1'b0;
    chk("wb_start", 32'({ram_req, ram_rw, ram_addr}), 32'({1'b1, 1'b1, 8'h12}));
    clr = 1'b1; ram_ack = 1'b1;
    step();
    clr = 1'b0; ram_ack = 1'b0;
    chk("clr_abort", 32'({ram_req, cpu_busy, cpu_ack}), 32'd0);
    model_reset();
    chk_counts();
    step();
    chk("clr_no_ack", 32'(cpu_ack), 32'd0);
    access(1'b0, 8'h12, 8'h00, 0);

    // stray ram_ack while idle, stray cpu_req while busy
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    chk("stray_ram_ack", 32'({ram_req, cpu_busy, cpu_ack}), 32'd0);
    chk_counts();
    access(1'b0, 8'h45, 8'h00, 1);
    step();
    chk("poke_not_queued", 32'({cpu_busy, cpu_ack}), 32'd0);
    chk_counts();

    // saturation of the narrow hit counter
    for (int i = 0; i < 20; i++) access(1'b0, 8'h45, 8'h00, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      access(1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
